net_drive_arbiter: RTL and testbench
====================================

NET_DRIVE_ARBITER -- requirements
Module: net_drive_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, giving the number of requesters competing for the shared net array.
REQ-002 The block SHALL have parameter W, default 6, giving the driven bits per requester, one 3x2 net array flattened as [3:1][2:1].
REQ-003 The block SHALL have parameter MAX_HOLD, default 4, giving the maximum consecutive cycles one owner may drive before forced rotation; legal range is 1..15.
REQ-004 The block SHALL have a single clock; reset is synchronous and active-high.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 req  input  N_REQ  per-requester drive request, level-sensitive.
REQ-008 rel  input  N_REQ  per-requester early release, sampled only for the current owner.
REQ-009 drv_data  input  N_REQ*W  requester i's net-array value in bits [i*W +: W].
REQ-010 gnt  output  N_REQ  one-hot grant, registered.
REQ-011 bus  output  W  resolved shared net-array value, registered.
REQ-012 bus_vld  output  1  bus carries a granted driver's value.
REQ-013 conflict  output  1  one-cycle pulse: an arbitration saw two or more requesters.

Function
REQ-014 The FSM SHALL have states IDLE, OWN and GAP, encoded internally.
REQ-015 IDLE: if any req bit is set, select the winner round-robin, searching from last_owner+1 modulo N_REQ; next cycle state=OWN, gnt=onehot(winner), hold_cnt=0, last_owner=winner.
REQ-016 IDLE with req=0 SHALL stay IDLE with gnt=0.
REQ-017 OWN, each cycle: bus <= drv_data[owner], bus_vld <= 1, hold_cnt <= hold_cnt+1.
REQ-018 OWN SHALL exit to GAP with gnt=0 next cycle when req[owner]=0, rel[owner]=1, or hold_cnt==MAX_HOLD-1; the owner's data in that exit cycle is still captured per REQ-017.
REQ-019 GAP SHALL last exactly one cycle with gnt=0, then behave as IDLE. This bubble guarantees no two drivers are ever granted in adjacent cycles.
REQ-020 bus_vld SHALL be 1 exactly in the cycle after each OWN cycle, i.e. one-cycle lag behind gnt; otherwise 0.
REQ-021 bus SHALL hold its last value when bus_vld=0.
REQ-022 Latency: req rising in IDLE at cycle n gives gnt at n+1, and bus_vld with that cycle's data at n+2.
REQ-023 conflict SHALL pulse in the cycle gnt is first asserted when popcount(req) >= 2 at the arbitration cycle; otherwise 0.
REQ-024 Forced rotation: with all requesters continuously requesting, owners SHALL rotate 0,1,2,3,0,... Each tenure is MAX_HOLD OWN cycles followed by one GAP cycle.
REQ-025 rel or req changes from non-owners SHALL NOT affect the current tenure.
REQ-026 hold_cnt SHALL be 4 bits and SHALL never exceed MAX_HOLD-1.
REQ-027 gnt SHALL always be zero or one-hot; no X on any output after reset.

Reset
REQ-028 With rst=1 at an edge, the block SHALL set state=IDLE, gnt=0, bus=0, bus_vld=0, conflict=0, hold_cnt=0, last_owner=N_REQ-1, so requester 0 has first priority.
REQ-029 Reset asserted mid-tenure SHALL drop gnt and bus_vld on the next edge and discard the tenure; rst has priority over all transitions.

Verification
REQ-030 Single requester: req=4'b0100 held, drv_data[2]=6'h2A, MAX_HOLD=4 -> gnt=0100 for 4 cycles; bus=6'h2A with bus_vld=1 for 4 cycles lagging by one; 1 GAP cycle; re-grant to requester 2; conflict=0 throughout.
REQ-031 Contention: req=4'b1111 from reset -> grants 0001,0010,0100,1000,0001, each 4 cycles with 1 GAP between; conflict pulses at each grant start.
REQ-032 Early release: owner 1 asserts rel in its 2nd OWN cycle -> gnt=0 in the following cycle, and bus_vld stays 1 for one more cycle carrying the 2nd-cycle data.
REQ-033 Request drop: owner 3 deasserts req in its 1st OWN cycle -> 1 OWN cycle total, then GAP; next winner is searched from requester 0.
REQ-034 Reset mid-tenure: rst pulsed during owner 2's 3rd OWN cycle -> next cycle gnt=0, bus=0, bus_vld=0; with req=1111 afterwards, requester 0 is granted first.
REQ-035 Scoreboard checks on every cycle: gnt is one-hot or zero; no grant in the cycle after a tenure ends; bus equals drv_data[owner] from the previous cycle whenever bus_vld=1.

Source files
------------

// File: rtl/net_drive_arbiter.sv
// Round-robin arbiter for a shared 3x2 net array. One requester owns the net
// at a time, for at most MAX_HOLD cycles. A one-cycle bubble separates every
// pair of tenures. The resolved value is registered onto bus one cycle after
// each owned cycle.
module net_drive_arbiter #(
   parameter int N_REQ    = 4,
   parameter int W        = 6,
   parameter int MAX_HOLD = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N_REQ-1:0]   req,
   input  logic [N_REQ-1:0]   rel,
   input  logic [N_REQ*W-1:0] drv_data,
   output logic [N_REQ-1:0]   gnt,
   output logic [W-1:0]       bus,
   output logic               bus_vld,
   output logic               conflict
);

   localparam int            OW        = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam logic [3:0]    HOLD_LAST = 4'(MAX_HOLD - 1);
   localparam logic [OW-1:0] OWNER_RST = OW'(N_REQ - 1);

   typedef enum logic [1:0] {IDLE = 2'd0, OWN = 2'd1, GAP = 2'd2} state_t;

   state_t           state_q, state_d;
   logic [N_REQ-1:0] gnt_q, gnt_d;
   logic [W-1:0]     bus_q, bus_d;
   logic             bus_vld_q, bus_vld_d;
   logic             conflict_q, conflict_d;
   logic [3:0]       hold_cnt_q, hold_cnt_d;
   logic [OW-1:0]    owner_q, owner_d;

   logic [OW-1:0]    idx;
   logic [OW-1:0]    winner;
   logic             found;
   logic             multi_req;
   logic             own_exit;
   logic [W-1:0]     own_data;

   // Round-robin search for the next winner, starting just after the last owner.
   // NOTE: every combinational output gets a default first, so no path leaves
   // a value unassigned and no latch is inferred.
   always_comb begin
      found  = 1'b0;
      winner = owner_q;
      idx    = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         idx = OW'((int'(owner_q) + k) % N_REQ);
         if (!found && req[idx]) begin
            found  = 1'b1;
            winner = idx;
         end
      end
   end

   assign multi_req = ($countones(req) > 1);

   // Select the current owner's slice of the flattened driver data.
   always_comb begin
      own_data = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (owner_q == OW'(i)) own_data = drv_data[i*W +: W];
      end
   end

   // Only the owner's own req/rel can end a tenure; other requesters are ignored.
   assign own_exit = !req[owner_q] || rel[owner_q] || (hold_cnt_q == HOLD_LAST);

   // State register: every flop is reset synchronously and rst beats all transitions.
   // NOTE: sequential state uses non-blocking assignments, so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         gnt_q      <= '0;
         bus_q      <= '0;
         bus_vld_q  <= 1'b0;
         conflict_q <= 1'b0;
         hold_cnt_q <= '0;
         owner_q    <= OWNER_RST;
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         bus_q      <= bus_d;
         bus_vld_q  <= bus_vld_d;
         conflict_q <= conflict_d;
         hold_cnt_q <= hold_cnt_d;
         owner_q    <= owner_d;
      end
   end

   // Next-state logic. The GAP cycle already arbitrates, so the bubble is exactly one cycle.
   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      hold_cnt_d = hold_cnt_q;
      case (state_q)
         IDLE, GAP: begin
            hold_cnt_d = '0;
            if (found) begin
               state_d = OWN;
               owner_d = winner;
            end else begin
               state_d = IDLE;
            end
         end
         OWN: begin
            if (own_exit) begin
               state_d    = GAP;
               hold_cnt_d = '0;
            end else begin
               hold_cnt_d = hold_cnt_q + 4'd1;
            end
         end
         default: begin
            state_d    = IDLE;
            hold_cnt_d = '0;
         end
      endcase
   end

   // Output logic: next values of the registered grant, bus and status pulses.
   always_comb begin
      gnt_d      = '0;
      bus_d      = bus_q;
      bus_vld_d  = 1'b0;
      conflict_d = 1'b0;
      case (state_q)
         IDLE, GAP: begin
            if (found) begin
               gnt_d[winner] = 1'b1;
               conflict_d    = multi_req;
            end
         end
         OWN: begin
            bus_d     = own_data;
            bus_vld_d = 1'b1;
            if (!own_exit) gnt_d[owner_q] = 1'b1;
         end
         default: ;
      endcase
   end

   assign gnt      = gnt_q;
   assign bus      = bus_q;
   assign bus_vld  = bus_vld_q;
   assign conflict = conflict_q;

endmodule

// File: tb/tb_net_drive_arbiter.sv
// Bench for net_drive_arbiter: a directed vector table, hand sequences for
// contention, early release, request drop and reset mid-tenure, then random
// traffic. A tenure-level reference model is checked on every cycle.
module tb_net_drive_arbiter;

   localparam int N_REQ    = 4;
   localparam int W        = 6;
   localparam int MAX_HOLD = 4;

   logic               clk = 1'b0;
   logic               rst;
   logic [N_REQ-1:0]   req;
   logic [N_REQ-1:0]   rel;
   logic [N_REQ*W-1:0] drv_data;
   logic [N_REQ-1:0]   gnt;
   logic [W-1:0]       bus;
   logic               bus_vld;
   logic               conflict;

   net_drive_arbiter #(.N_REQ(N_REQ), .W(W), .MAX_HOLD(MAX_HOLD)) dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .rel      (rel),
      .drv_data (drv_data),
      .gnt      (gnt),
      .bus      (bus),
      .bus_vld  (bus_vld),
      .conflict (conflict)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Reference model. It tracks tenures rather than FSM states. m_owner < 0
   // means nobody owns the net. A cycle with no owner arbitrates, which also
   // covers the bubble after a tenure.
   int               m_owner, m_cnt, m_last;
   logic [N_REQ-1:0] m_gnt;
   logic [W-1:0]     m_bus;
   logic             m_vld, m_conf;
   logic [N_REQ-1:0] prev_gnt = '0;

   task automatic model_step();
      logic [N_REQ-1:0] ng = '0;
      logic [W-1:0]     nb = m_bus;
      logic             nv = 1'b0;
      logic             nc = 1'b0;
      if (rst) begin
         m_owner = -1; m_cnt = 0; m_last = N_REQ - 1;
         m_gnt = '0; m_bus = '0; m_vld = 1'b0; m_conf = 1'b0;
         return;
      end
      if (m_owner >= 0) begin
         nv = 1'b1;
         nb = drv_data[m_owner*W +: W];
         m_cnt++;
         if (!req[m_owner] || rel[m_owner] || m_cnt == MAX_HOLD) m_owner = -1;
         else ng[m_owner] = 1'b1;
      end else if (req != '0) begin
         for (int k = 1; k <= N_REQ; k++) begin
            int c = (m_last + k) % N_REQ;
            if (m_owner < 0 && req[c]) m_owner = c;
         end
         m_last = m_owner;
         m_cnt  = 0;
         ng[m_owner] = 1'b1;
         nc = ($countones(req) >= 2);
      end
      m_gnt = ng; m_bus = nb; m_vld = nv; m_conf = nc;
   endtask

   // One clock: advance the model with the applied inputs, then compare #1 after the edge.
   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
      check("model_gnt",      32'(gnt),      32'(m_gnt));
      check("model_bus",      32'(bus),      32'(m_bus));
      check("model_bus_vld",  32'(bus_vld),  32'(m_vld));
      check("model_conflict", 32'(conflict), 32'(m_conf));
      check("gnt_onehot0",    32'($onehot0(gnt)), 32'd1);
      if (prev_gnt != '0 && gnt != '0) check("gnt_adjacent", 32'(gnt), 32'(prev_gnt));
      prev_gnt = gnt;
   endtask

   task automatic do_reset();
      rst = 1'b1; req = '0; rel = '0;
      cycle();
      rst = 1'b0;
   endtask

   typedef struct {
      logic               rst;
      logic [N_REQ-1:0]   req;
      logic [N_REQ-1:0]   rel;
      logic [N_REQ*W-1:0] data;
      logic [N_REQ-1:0]   gnt;
      logic [W-1:0]       bus;
      logic               vld;
      logic               conf;
   } vec_t;

   function automatic vec_t mk(logic r, logic [N_REQ-1:0] rq, logic [N_REQ-1:0] rl,
                               logic [N_REQ*W-1:0] d, logic [N_REQ-1:0] g,
                               logic [W-1:0] b, logic v, logic cf);
      vec_t t;
      t.rst = r; t.req = rq; t.rel = rl; t.data = d;
      t.gnt = g; t.bus = b; t.vld = v; t.conf = cf;
      return t;
   endfunction

   vec_t tbl [9];

   initial begin
      logic [N_REQ*W-1:0] d_single;
      rst = 1'b1; req = '0; rel = '0; drv_data = '0;

      // Single requester 2 holding the net, then a reset in the middle of a tenure.
      d_single = {6'h11, 6'h2A, 6'h05, 6'h33};
      tbl[0] = mk(1'b1, 4'b0000, 4'b0000, d_single, 4'b0000, 6'h00, 1'b0, 1'b0);
      tbl[1] = mk(1'b0, 4'b0100, 4'b0000, d_single, 4'b0100, 6'h00, 1'b0, 1'b0);
      tbl[2] = mk(1'b0, 4'b0100, 4'b1011, d_single, 4'b0100, 6'h2A, 1'b1, 1'b0);
      tbl[3] = mk(1'b0, 4'b0100, 4'b0000, d_single, 4'b0100, 6'h2A, 1'b1, 1'b0);
      tbl[4] = mk(1'b0, 4'b0100, 4'b0000, d_single, 4'b0100, 6'h2A, 1'b1, 1'b0);
      tbl[5] = mk(1'b0, 4'b0100, 4'b0000, d_single, 4'b0000, 6'h2A, 1'b1, 1'b0);
      tbl[6] = mk(1'b0, 4'b0100, 4'b0000, d_single, 4'b0100, 6'h2A, 1'b0, 1'b0);
      tbl[7] = mk(1'b0, 4'b0100, 4'b0000, d_single, 4'b0100, 6'h2A, 1'b1, 1'b0);
      tbl[8] = mk(1'b1, 4'b0100, 4'b0000, d_single, 4'b0000, 6'h00, 1'b0, 1'b0);

      for (int i = 0; i < 9; i++) begin
         rst = tbl[i].rst; req = tbl[i].req; rel = tbl[i].rel; drv_data = tbl[i].data;
         cycle();
         check($sformatf("tbl%0d_gnt", i),  32'(gnt),      32'(tbl[i].gnt));
         check($sformatf("tbl%0d_bus", i),  32'(bus),      32'(tbl[i].bus));
         check($sformatf("tbl%0d_vld", i),  32'(bus_vld),  32'(tbl[i].vld));
         check($sformatf("tbl%0d_conf", i), 32'(conflict), 32'(tbl[i].conf));
      end

      // Contention: all four requesting rotate 0,1,2,3,0 with one bubble each.
      do_reset();
      req = 4'b1111; drv_data = {6'h04, 6'h03, 6'h02, 6'h01};
      for (int t = 0; t < 5; t++) begin
         for (int c = 0; c < MAX_HOLD; c++) begin
            cycle();
            check($sformatf("rot%0d_gnt", t), 32'(gnt), 32'(4'b0001 << (t % N_REQ)));
            check($sformatf("rot%0d_conf", t), 32'(conflict), 32'(c == 0));
         end
         cycle();
         check($sformatf("rot%0d_gap", t), 32'(gnt), 32'd0);
      end

      // Early release: owner 1 raises rel in its second owned cycle.
      do_reset();
      req = 4'b0010; drv_data = {6'h00, 6'h00, 6'h09, 6'h00};
      cycle();
      check("rel_gnt0", 32'(gnt), 32'(4'b0010));
      drv_data = {6'h00, 6'h00, 6'h0A, 6'h00};
      cycle();
      check("rel_gnt1", 32'(gnt), 32'(4'b0010));
      check("rel_bus1", 32'(bus), 32'h0A);
      drv_data = {6'h00, 6'h00, 6'h1B, 6'h00}; rel = 4'b0010;
      cycle();
      check("rel_gnt2", 32'(gnt), 32'd0);
      check("rel_vld2", 32'(bus_vld), 32'd1);
      check("rel_bus2", 32'(bus), 32'h1B);
      drv_data = {6'h00, 6'h00, 6'h3C, 6'h00}; rel = '0; req = '0;
      cycle();
      check("rel_vld3", 32'(bus_vld), 32'd0);
      check("rel_hold3", 32'(bus), 32'h1B);

      // Request drop: owner 3 drops req at once; the search restarts from requester 0.
      do_reset();
      req = 4'b1000;
      cycle();
      check("drop_gnt0", 32'(gnt), 32'(4'b1000));
      req = 4'b0111;
      cycle();
      check("drop_gnt1", 32'(gnt), 32'd0);
      check("drop_vld1", 32'(bus_vld), 32'd1);
      cycle();
      check("drop_gnt2", 32'(gnt), 32'(4'b0001));
      check("drop_conf2", 32'(conflict), 32'd1);

      // Reset during owner 2's third owned cycle.
      do_reset();
      req = 4'b0100; drv_data = {6'h00, 6'h15, 6'h00, 6'h00};
      cycle(); cycle(); cycle();
      check("rstmid_pre_vld", 32'(bus_vld), 32'd1);
      rst = 1'b1;
      cycle();
      check("rstmid_gnt", 32'(gnt), 32'd0);
      check("rstmid_bus", 32'(bus), 32'd0);
      check("rstmid_vld", 32'(bus_vld), 32'd0);
      rst = 1'b0; req = 4'b1111;
      cycle();
      check("rstmid_first", 32'(gnt), 32'(4'b0001));

      // Random traffic against the model.
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 3) == 0) req = 4'($urandom());
         rel = ($urandom_range(0, 7) == 0) ? 4'($urandom()) : 4'b0000;
         drv_data = 24'($urandom());
         rst = ($urandom_range(0, 199) == 0);
         cycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
